// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher: one request per cycle to a 1-cycle-latency
// instruction memory, buffering {instr, pc} pairs in a small FIFO for decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]     DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            run_q, run_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [CW:0]     used_s;
  logic            req_s;
  logic            valid_s;
  logic            push_s;
  logic            pop_s;

  // The in-flight request already owns a slot, so it is counted against the credit.
  assign used_s  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign req_s   = run_q && !redirect && (used_s < DEPTH_L);
  assign valid_s = (count_q != '0) && !redirect;
  assign push_s  = inflight_q && !redirect;
  assign pop_s   = valid_s && instr_ready;

  assign imem_addr   = fetch_pc_q;
  assign imem_req    = req_s;
  assign instr_valid = valid_s;
  assign instr       = instr_mem_q[rptr_q];
  assign instr_pc    = pc_mem_q[rptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    run_d         = 1'b1;
    inflight_d    = 1'b0;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & PC_MASK;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (req_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end else begin
        inflight_d = 1'b0;
      end
      if (push_s) begin
        wptr_d = wptr_q + 1'b1;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + 1'b1;
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      run_q         <= 1'b0;
      inflight_q    <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      run_q         <= run_d;
      inflight_q    <= inflight_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read as zero while held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push_s) begin
      instr_mem_q[wptr_q] <= imem_rdata;
      pc_mem_q[wptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage that sits between the synchronous instruction memory and the core's decode input. It generates sequential fetch addresses, issues one request per cycle to `instr_mem` (1-cycle read latency) and buffers returned instructions with their PCs in a small FIFO. It presents them to the core through a valid/ready handshake, and flushes on a control-flow redirect.

## Interface
- `XLEN`, 32: data and address width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (low = in reset).
- `imem_addr`  out  XLEN: fetch address to instruction memory.
- `imem_req`  out  1: request issued this cycle.
- `imem_rdata`  in  XLEN: instruction for the request issued the previous cycle.
- `redirect`  in  1: taken branch or jump; flushes the queue.
- `redirect_pc`  in  XLEN: new fetch address; bits [1:0] ignored (treated as 0).
- `instr_valid`  out  1: `instr`/`instr_pc` hold a valid entry.
- `instr`  out  XLEN: head-of-queue instruction.
- `instr_pc`  out  XLEN: PC of `instr`.
- `instr_ready`  in  1: consumer accepts the head entry this cycle.

## Operation
- State:
  - `fetch_pc` (next address to request).
  - `run` flag.
  - `inflight` flag with its captured address `inflight_pc`.
  - FIFO of `DEPTH` {instr, pc} entries with read/write pointers of width log2(DEPTH), plus `count` (0..DEPTH).
- Request rule:
  - `imem_req` = `run` && !`redirect` && (`count` + `inflight` < `DEPTH`).
  - `imem_addr` = `fetch_pc` at all times.
  - On request: `inflight` ← 1, `inflight_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc` + 4 (mod 2^XLEN, wraps 0xFFFF_FFFC → 0).
  - With no request, `inflight` ← 0.
- Response: when `inflight` = 1 and no `redirect`, {`imem_rdata`, `inflight_pc`} is written at the write pointer.
  - The credit rule guarantees space, so a response is never dropped for lack of room.
- Dequeue: `instr_valid` = (`count` ≠ 0) && !`redirect`. A pop occurs when `instr_valid` && `instr_ready`.
- Simultaneous push and pop: both pointers advance, `count` unchanged. Pop from a 1-entry queue with a push in the same cycle is legal.
- Pointer wrap: pointers wrap modulo `DEPTH`. Full is `count` = `DEPTH`; empty is `count` = 0.
- Redirect (highest priority) takes effect at the clock edge ending the cycle in which `redirect` = 1:
  - `count` ← 0 and both pointers ← 0.
  - An in-flight response arriving that cycle is discarded, and `inflight` ← 0.
  - `fetch_pc` ← {`redirect_pc`[XLEN-1:2], 2'b00}.
  - No request and no pop occur in the redirect cycle (`instr_ready` is ignored).
- Back-to-back redirects: each one reloads `fetch_pc`, and the last one wins.
- `instr_ready` without `instr_valid` has no effect.

## Timing
- Reset values (held while `reset` = 0):
  - `run` = 0, `inflight` = 0, `count` = 0, pointers = 0, `fetch_pc` = `RESET_PC`.
  - Outputs: `imem_req` = 0, `instr_valid` = 0, `imem_addr` = `RESET_PC`; `instr` and `instr_pc` read as 0.
- Assertion of `reset` mid-operation clears all state immediately, without waiting for a clock edge. Queued and in-flight instructions are lost.
- Startup sequence:
  - Edge E0, the first rising edge after `reset` rises, sets `run`.
  - Cycle after E0: first request, for `RESET_PC`.
  - Next cycle: `imem_rdata` is valid and is written.
  - Following cycle: `instr_valid` = 1.
- Fetch-to-valid latency is 2 cycles (request cycle + response cycle). The same 2-cycle latency applies after a redirect, measured from the first post-redirect request.
- Throughput: with `instr_ready` held high, one instruction per cycle in steady state.
- Stall: with `instr_ready` = 0, requests stop once `count` + `inflight` = `DEPTH`. The queue then holds exactly `DEPTH` entries with none lost.
- All outputs except `imem_req` and `instr_valid` come from registers or RAM. Those two also depend combinationally on `redirect`.

## Test plan
- Reset release, `instr_ready` = 1, memory returns word = address: `instr_pc`/`instr` = 0x0, 0x4, 0x8, … with the first valid 3 cycles after E0 and one per cycle after.
- `instr_ready` = 0 for 10 cycles after start: exactly 4 requests (0x0–0xC); then `imem_req` = 0 and `instr_valid` = 1 holding 0x0. Release gives 0x0, 0x4, 0x8, 0xC, 0x10 in order with no gaps beyond the refill.
- Redirect to 0x100 while 2 entries are queued and one is in flight: no pop that cycle. Next cycle `imem_addr` = 0x100, and the next valid `instr_pc` is 0x100; 0x8/0xC never appear.
- Redirect with `redirect_pc` = 0x203: fetch resumes at 0x200.
- `RESET_PC` = 0xFFFF_FFF8: the sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Pull `reset` low asynchronously mid-stream with a full queue: `instr_valid` and `imem_req` drop to 0 before the next edge, and after release fetch restarts at `RESET_PC`.
